// File: rtl/tomasulo_regfile.sv
// Architectural register file with a Tomasulo register-status table (busy bit + producer ROB tag per register).
// Reads are combinational with a commit-to-read bypass; commits, renames and flushes update state on the clock edge.
module tomasulo_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int TAG_W = 4,
    parameter int NRD   = 2,
    parameter int NCMT  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic                  ren_en,
    input  logic [AW-1:0]         ren_addr,
    input  logic [TAG_W-1:0]      ren_tag,
    input  logic [NCMT-1:0]       cmt_en,
    input  logic [NCMT*AW-1:0]    cmt_addr,
    input  logic [NCMT*TAG_W-1:0] cmt_tag,
    input  logic [NCMT*XLEN-1:0]  cmt_data,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_vec
);

    logic [XLEN-1:0]  value_q [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [NREG-1:0]  busy_q;

    logic [NREG-1:0]  wr_hit;
    logic [XLEN-1:0]  wr_data [NREG];
    logic [TAG_W-1:0] wr_tag  [NREG];

    logic [AW-1:0]    ra;
    logic             bp_hit;
    logic [XLEN-1:0]  bp_data;
    logic [TAG_W-1:0] bp_tag;

    // Per-register commit winner: ports scanned in ascending order so the youngest enabled port wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
            wr_tag[r]  = '0;
            for (int j = 0; j < NCMT; j++) begin
                if (cmt_en[j] && cmt_addr[j*AW +: AW] == AW'(r)) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = cmt_data[j*XLEN +: XLEN];
                    wr_tag[r]  = cmt_tag[j*TAG_W +: TAG_W];
                end
            end
        end
        wr_hit[0] = 1'b0;
    end

    // Register 0 is never written after reset, so it stays value 0, not busy, tag 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit[r])
                    value_q[r] <= wr_data[r];
                if (flush) begin
                    busy_q[r] <= 1'b0;
                end else if (ren_en && ren_addr == AW'(r)) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= ren_tag;
                end else if (wr_hit[r] && busy_q[r] && tag_q[r] == wr_tag[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // Read ports see committing values this cycle but not a same-cycle rename.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        ra      = '0;
        bp_hit  = 1'b0;
        bp_data = '0;
        bp_tag  = '0;
        for (int i = 0; i < NRD; i++) begin
            ra      = rd_addr[i*AW +: AW];
            bp_hit  = 1'b0;
            bp_data = '0;
            bp_tag  = '0;
            for (int j = 0; j < NCMT; j++) begin
                if (cmt_en[j] && cmt_addr[j*AW +: AW] == ra) begin
                    bp_hit  = 1'b1;
                    bp_data = cmt_data[j*XLEN +: XLEN];
                    bp_tag  = cmt_tag[j*TAG_W +: TAG_W];
                end
            end
            if (reset_n && ra != '0) begin
                rd_data[i*XLEN +: XLEN]   = bp_hit ? bp_data : value_q[ra];
                rd_busy[i]                = busy_q[ra] && !(bp_hit && bp_tag == tag_q[ra]);
                rd_tag[i*TAG_W +: TAG_W]  = tag_q[ra];
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_tomasulo_regfile.sv
// Directed bench for tomasulo_regfile: a register-status model checked every cycle plus literal expectations.
module tb_tomasulo_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;
    localparam int NCMT  = 2;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NRD*TAG_W-1:0]  rd_tag;
    logic                  ren_en;
    logic [AW-1:0]         ren_addr;
    logic [TAG_W-1:0]      ren_tag;
    logic [NCMT-1:0]       cmt_en;
    logic [NCMT*AW-1:0]    cmt_addr;
    logic [NCMT*TAG_W-1:0] cmt_tag;
    logic [NCMT*XLEN-1:0]  cmt_data;
    logic                  flush;
    logic [NREG-1:0]       busy_vec;

    int checks = 0;
    int errors = 0;
    logic run = 1'b0;

    tomasulo_regfile #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .TAG_W(TAG_W), .NRD(NRD), .NCMT(NCMT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
        .cmt_en(cmt_en), .cmt_addr(cmt_addr), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
        .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // Reference state: plain arrays of value, busy and tag per register.
    logic [XLEN-1:0]  m_val [NREG];
    logic [TAG_W-1:0] m_tag [NREG];
    logic [NREG-1:0]  m_busy;
    logic [XLEN-1:0]  md;
    logic [TAG_W-1:0] mt;

    function automatic logic cmt_win(input int r, output logic [XLEN-1:0] d, output logic [TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        d = '0;
        t = '0;
        for (int j = NCMT-1; j >= 0; j--) begin
            if (!hit && cmt_en[j] && int'(cmt_addr[j*AW +: AW]) == r) begin
                hit = 1'b1;
                d = cmt_data[j*XLEN +: XLEN];
                t = cmt_tag[j*TAG_W +: TAG_W];
            end
        end
        return hit;
    endfunction

    function automatic void exp_read(input int a, output logic [XLEN-1:0] d, output logic b,
                                     output logic [TAG_W-1:0] t);
        logic [XLEN-1:0]  cd;
        logic [TAG_W-1:0] ct;
        d = '0;
        b = 1'b0;
        t = '0;
        if (reset_n && a != 0) begin
            d = m_val[a];
            b = m_busy[a];
            t = m_tag[a];
            if (cmt_win(a, cd, ct)) begin
                d = cd;
                if (m_busy[a] && ct == m_tag[a])
                    b = 1'b0;
            end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                m_val[r] <= '0;
                m_tag[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (cmt_win(r, md, mt)) begin
                    m_val[r] <= md;
                    if (m_busy[r] && m_tag[r] == mt)
                        m_busy[r] <= 1'b0;
                end
            end
            if (ren_en && !flush && ren_addr != 0) begin
                m_busy[ren_addr] <= 1'b1;
                m_tag[ren_addr]  <= ren_tag;
            end
            if (flush)
                m_busy <= '0;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            logic [XLEN-1:0]  d;
            logic             b;
            logic [TAG_W-1:0] t;
            for (int p = 0; p < NRD; p++) begin
                exp_read(int'(rd_addr[p*AW +: AW]), d, b, t);
                check($sformatf("model_data_p%0d@%0t", p, $time), 64'(rd_data[p*XLEN +: XLEN]), 64'(d));
                check($sformatf("model_busy_p%0d@%0t", p, $time), 64'(rd_busy[p]), 64'(b));
                check($sformatf("model_tag_p%0d@%0t", p, $time), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
            end
            check($sformatf("model_busy_vec@%0t", $time), 64'(busy_vec), 64'(m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ren_en = 1'b0; ren_addr = '0; ren_tag = '0;
        cmt_en = '0; cmt_addr = '0; cmt_tag = '0; cmt_data = '0;
        flush = 1'b0;
    endtask

    task automatic ren(input int a, input int t);
        ren_en = 1'b1; ren_addr = AW'(a); ren_tag = TAG_W'(t);
    endtask

    task automatic cmt(input int p, input int a, input int t, input logic [XLEN-1:0] d);
        cmt_en[p] = 1'b1;
        cmt_addr[p*AW +: AW] = AW'(a);
        cmt_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
        cmt_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic exp_rd(input string nm, input int p, input logic [XLEN-1:0] d, input logic b, input int t);
        check({nm, "_data"}, 64'(rd_data[p*XLEN +: XLEN]), 64'(d));
        check({nm, "_busy"}, 64'(rd_busy[p]), 64'(b));
        check({nm, "_tag"}, 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rd(0, 0);
        rd(1, 5);
        #2 reset_n = 1'b0;
        run = 1'b1;
        #1;
        exp_rd("rst_x0", 0, 32'h0, 1'b0, 0);
        exp_rd("rst_x5", 1, 32'h0, 1'b0, 0);
        check("rst_busy_vec", 64'(busy_vec), 64'h0);
        cmt(0, 5, 0, 32'h0000ABCD);
        #1 exp_rd("rst_bypass_x5", 1, 32'h0, 1'b0, 0);
        idle();
        tick();
        tick();
        reset_n = 1'b1;

        cmt(0, 0, 0, 32'hDEADBEEF);
        #1 exp_rd("x0_bypass", 0, 32'h0, 1'b0, 0);
        tick(); idle();
        #1 exp_rd("x0_after", 0, 32'h0, 1'b0, 0);

        ren(3, 7);
        tick(); idle(); rd(0, 3);
        #1 exp_rd("x3_renamed", 0, 32'h0, 1'b1, 7);
        cmt(0, 3, 7, 32'h1234);
        #1 exp_rd("x3_commit_bypass", 0, 32'h1234, 1'b0, 7);
        tick(); idle();
        #1 check("x3_busy_vec", 64'(busy_vec[3]), 64'h0);
        exp_rd("x3_after", 0, 32'h1234, 1'b0, 7);

        ren(4, 2);
        tick(); idle(); ren(4, 5);
        tick(); idle(); cmt(0, 4, 2, 32'hAA); rd(0, 4);
        #1 exp_rd("x4_stale_bypass", 0, 32'hAA, 1'b1, 5);
        tick(); idle();
        #1 exp_rd("x4_stale_after", 0, 32'hAA, 1'b1, 5);

        cmt(0, 6, 0, 32'h11); cmt(1, 6, 0, 32'h22); rd(1, 6);
        #1 exp_rd("x6_dual_bypass", 1, 32'h22, 1'b0, 0);
        tick(); idle();
        #1 exp_rd("x6_dual_after", 1, 32'h22, 1'b0, 0);

        ren(8, 3);
        tick(); idle(); cmt(0, 8, 3, 32'h55); ren(8, 9); rd(0, 8);
        #1 exp_rd("x8_ren_cmt_bypass", 0, 32'h55, 1'b0, 3);
        tick(); idle();
        #1 exp_rd("x8_ren_cmt_after", 0, 32'h55, 1'b1, 9);
        cmt(0, 8, 9, 32'h66); cmt(1, 8, 1, 32'h77);
        #1 exp_rd("x8_young_mismatch", 0, 32'h77, 1'b1, 9);
        tick(); idle();
        #1 exp_rd("x8_young_mismatch_after", 0, 32'h77, 1'b1, 9);
        cmt(0, 8, 1, 32'h88); cmt(1, 8, 9, 32'h99);
        #1 exp_rd("x8_young_match", 0, 32'h99, 1'b0, 9);
        tick(); idle();
        #1 exp_rd("x8_young_match_after", 0, 32'h99, 1'b0, 9);

        ren(1, 1);
        tick(); idle(); ren(2, 2);
        tick(); idle(); ren(9, 3);
        tick(); idle();
        #1 check("pre_flush_busy_vec", 64'(busy_vec), 64'h216);
        flush = 1'b1; ren(10, 6); cmt(0, 12, 0, 32'h77);
        tick(); idle(); rd(0, 10); rd(1, 12);
        #1 check("flush_busy_vec", 64'(busy_vec), 64'h0);
        exp_rd("flush_x10", 0, 32'h0, 1'b0, 0);
        exp_rd("flush_x12", 1, 32'h77, 1'b0, 0);
        rd(0, 4);
        #1 exp_rd("flush_x4_tag_kept", 0, 32'hAA, 1'b0, 5);

        ren(5, 4);
        tick(); idle();
        ren(7, 2); cmt(0, 3, 0, 32'h5555); rd(0, 5); rd(1, 3);
        #1 exp_rd("pre_rst_x5", 0, 32'h0, 1'b1, 4);
        #1 reset_n = 1'b0;
        #1 check("async_rst_busy_vec", 64'(busy_vec), 64'h0);
        exp_rd("async_rst_x5", 0, 32'h0, 1'b0, 0);
        exp_rd("async_rst_x3", 1, 32'h0, 1'b0, 0);
        tick();
        idle();
        tick();
        reset_n = 1'b1;
        rd(0, 7); rd(1, 3);
        #1 check("post_rst_busy_vec", 64'(busy_vec), 64'h0);
        exp_rd("post_rst_x7", 0, 32'h0, 1'b0, 0);
        exp_rd("post_rst_x3", 1, 32'h0, 1'b0, 0);

        for (int n = 0; n < 80; n++) begin
            idle();
            ren_en = 1'($urandom_range(0, 1));
            ren_addr = AW'($urandom_range(0, 7));
            ren_tag = TAG_W'($urandom_range(0, 3));
            flush = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < NCMT; p++) begin
                if ($urandom_range(0, 1) == 1)
                    cmt(p, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), XLEN'($urandom));
            end
            rd(0, int'($urandom_range(0, 7)));
            rd(1, int'($urandom_range(0, 7)));
            tick();
        end

        idle();
        tick();
        tick();
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
